// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: FSM states, segment encodings, anode helpers.
// No logic of its own; latency and backpressure do not apply.
package seven_seg_scanner_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_DISPLAY,
        ST_BLANK
    } state_t;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

    // Active-low {g..a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [MAX_DIGITS-1:0] anode_on(input logic [2:0] idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Register sources, frame controls and display pins of the seven-segment scanner.
// Pure wiring; the pins are registered inside the scanner, no backpressure.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 32
);
    logic [DATA_W-1:0]     R0;
    logic [DATA_W-1:0]     R1;
    logic                  src_sel;
    logic [2:0]            page;
    logic                  lz_en;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic [6:0]            seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_done;

    modport master (
        output R0, R1, src_sel, page, lz_en, dp_mask,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  R0, R1, src_sel, page, lz_en, dp_mask,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern {g..a}.
// Purely combinational, zero latency, no backpressure.
module seven_seg_scanner_hex_to_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[nibble];
endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with per-frame snapshot, blanking and leading-zero suppression.
// Pins lag the scan state by one clk; free-running with no backpressure.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_W       = 32,
    parameter int DIGIT_CYCLES = 65536,
    parameter int BLANK_CYCLES = 256
) (
    input logic              clk,
    input logic              reset,
    seven_seg_scanner_if.slave bus
);
    localparam int SNAP_W  = 4 * NUM_DIGITS;
    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] B_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    state_t                state;
    logic [IW-1:0]         idx;
    logic [CW-1:0]         cnt;
    logic [SNAP_W-1:0]     snap;
    logic                  lz_s;
    logic [NUM_DIGITS-1:0] dp_s;

    logic [DATA_W-1:0]     src;
    logic [SNAP_W-1:0]     window;
    logic [3:0]            nib;
    logic [6:0]            seg_dec;
    logic                  tail_zero;
    logic                  dp_bit;
    logic                  dark;
    logic                  digit_end;
    logic [NUM_DIGITS-1:0] an_on;

    // Nibbles past the end of the source shift in as zero, so out-of-range pages read 0.
    always_comb begin
        src    = bus.src_sel ? bus.R1 : bus.R0;
        window = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            window[4*k +: 4] = 4'(src >> (4 * (int'(bus.page) * NUM_DIGITS + k)));
        end
        nib       = 4'(snap >> {idx, 2'b00});
        tail_zero = ((snap >> {idx, 2'b00}) == '0);
        dp_bit    = 1'(dp_s >> idx);
        dark      = lz_s && (idx != '0) && tail_zero && !dp_bit;
        an_on     = NUM_DIGITS'(anode_on(3'(idx)));
        digit_end = ((state == ST_DISPLAY) && (cnt == D_LAST) && (BLANK_CYCLES == 0)) ||
                    ((state == ST_BLANK) && (cnt == B_LAST));
    end

    seven_seg_scanner_hex_to_seg u_hex_to_seg (
        .nibble (nib),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_LOAD;
            idx            <= '0;
            cnt            <= '0;
            snap           <= '0;
            lz_s           <= 1'b0;
            dp_s           <= '0;
            bus.an         <= NUM_DIGITS'(ANODES_OFF);
            bus.seg        <= SEG_OFF;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.an         <= NUM_DIGITS'(ANODES_OFF);
            bus.seg        <= SEG_OFF;
            bus.dp         <= 1'b1;

            case (state)
                ST_LOAD: begin
                    snap           <= window;
                    lz_s           <= bus.lz_en;
                    dp_s           <= bus.dp_mask;
                    bus.frame_done <= 1'b1;
                    idx            <= '0;
                    cnt            <= '0;
                    state          <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    // Suppressed digits stay dark but keep their slot so the scan period is fixed.
                    if (!dark) begin
                        bus.an  <= an_on;
                        bus.seg <= seg_dec;
                        bus.dp  <= ~dp_bit;
                    end
                    if (cnt == D_LAST) begin
                        cnt <= '0;
                        if (BLANK_CYCLES > 0) state <= ST_BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt == B_LAST) cnt <= '0;
                    else               cnt <= cnt + 1'b1;
                end
                default: state <= ST_LOAD;
            endcase

            // Frame wrap re-snapshots everything so a frame is never torn by mid-scan input changes.
            if (digit_end) begin
                state <= ST_DISPLAY;
                if (idx == I_LAST) begin
                    idx            <= '0;
                    snap           <= window;
                    lz_s           <= bus.lz_en;
                    dp_s           <= bus.dp_mask;
                    bus.frame_done <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4-digit instance with blanking, 8-digit instance without.
module tb_seven_seg_scanner;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb4[$];
    exp_t sb8[$];

    always #5 clk = ~clk;

    seven_seg_scanner_if #(.NUM_DIGITS(4), .DATA_W(32)) if4 ();
    seven_seg_scanner_if #(.NUM_DIGITS(8), .DATA_W(32)) if8 ();

    seven_seg_scanner #(.NUM_DIGITS(4), .DATA_W(32), .DIGIT_CYCLES(4), .BLANK_CYCLES(1)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    seven_seg_scanner #(.NUM_DIGITS(8), .DATA_W(32), .DIGIT_CYCLES(2), .BLANK_CYCLES(0)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of one 4-digit frame: a display entry and a blank entry per digit.
    task automatic push_frame4(input logic [31:0] r0, input logic [31:0] r1, input logic sel,
                               input logic [2:0] pg, input logic lz, input logic [3:0] dm);
        logic [31:0] src;
        logic [3:0]  nib [4];
        logic        zero_tail;
        exp_t        e;
        int          pos;
        src = sel ? r1 : r0;
        for (int k = 0; k < 4; k++) begin
            pos = int'(pg) * 4 + k;
            nib[k] = 4'h0;
            if (pos < 8) nib[k] = src[4*pos +: 4];
        end
        for (int k = 0; k < 4; k++) begin
            zero_tail = 1'b1;
            for (int j = k; j < 4; j++) if (nib[j] != 4'h0) zero_tail = 1'b0;
            if (lz && k > 0 && zero_tail && !dm[k]) begin
                e = '{an: 8'h0F, seg: 7'h7F, dp: 1'b1};
            end else begin
                e.an  = 8'h0F & ~(8'h01 << k);
                e.seg = DEC[nib[k]];
                e.dp  = ~dm[k];
            end
            sb4.push_back(e);
            sb4.push_back('{an: 8'h0F, seg: 7'h7F, dp: 1'b1});
        end
    endtask

    task automatic wait_fd4(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if4.frame_done && n < 200);
        chk("fd4_wait", 32'(if4.frame_done), 1);
    endtask

    // Entered on the sample where frame_done is visible; ends on the next frame_done sample.
    task automatic check_frame4(input int chg_d, input logic [31:0] chg_val);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            if (sb4.size() < 2) begin
                chk("sb4_underflow", 32'(sb4.size()), 2);
                return;
            end
            e = sb4.pop_front();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (d == chg_d && c == 0) if4.R0 = chg_val;
                chk($sformatf("d%0d_c%0d_an", d, c), 32'(if4.an), 32'(e.an[3:0]));
                chk($sformatf("d%0d_c%0d_seg", d, c), 32'(if4.seg), 32'(e.seg));
                chk($sformatf("d%0d_c%0d_dp", d, c), 32'(if4.dp), 32'(e.dp));
            end
            e = sb4.pop_front();
            @(negedge clk);
            chk($sformatf("blank%0d_an", d), 32'(if4.an), 32'(e.an[3:0]));
            chk($sformatf("blank%0d_seg", d), 32'(if4.seg), 32'(e.seg));
            chk($sformatf("blank%0d_dp", d), 32'(if4.dp), 32'(e.dp));
            chk($sformatf("blank%0d_fd", d), 32'(if4.frame_done), (d == 3) ? 1 : 0);
        end
    endtask

    initial begin
        int   n;
        exp_t e;

        if4.R0 = 32'h0000_1234; if4.R1 = 32'hDEAD_BEEF; if4.src_sel = 1'b0;
        if4.page = 3'd0; if4.lz_en = 1'b0; if4.dp_mask = 4'b0000;
        if8.R0 = 32'hFFFF_FFFF; if8.R1 = 32'hFFFF_FFFF; if8.src_sel = 1'b0;
        if8.page = 3'd1; if8.lz_en = 1'b0; if8.dp_mask = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_an", 32'(if4.an), 32'hF);
        chk("rst_seg", 32'(if4.seg), 32'h7F);
        chk("rst_dp", 32'(if4.dp), 1);
        chk("rst_fd", 32'(if4.frame_done), 0);
        chk("rst_an8", 32'(if8.an), 32'hFF);

        // Plain scan of R0 page 0.
        push_frame4(32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 3'd0, 1'b0, 4'b0000);
        reset = 1'b1;
        wait_fd4(n);
        chk("first_fd_latency", 32'(n), 1);
        check_frame4(-1, 32'h0);

        // R1, page 1: inputs changed now only land at the frame after next.
        if4.src_sel = 1'b1; if4.page = 3'd1;
        push_frame4(32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 3'd1, 1'b0, 4'b0000);
        wait_fd4(n);
        chk("period_r1", 32'(n), 20);
        check_frame4(-1, 32'h0);

        // Leading-zero suppression with a decimal point holding digit 2 lit.
        if4.src_sel = 1'b0; if4.page = 3'd0; if4.R0 = 32'h0000_0050;
        if4.lz_en = 1'b1; if4.dp_mask = 4'b0100;
        push_frame4(32'h0000_0050, 32'hDEAD_BEEF, 1'b0, 3'd0, 1'b1, 4'b0100);
        wait_fd4(n);
        check_frame4(-1, 32'h0);

        // Source change at digit 2 must not tear the current frame.
        if4.R0 = 32'h0000_1111; if4.lz_en = 1'b0; if4.dp_mask = 4'b0000;
        push_frame4(32'h0000_1111, 32'h0, 1'b0, 3'd0, 1'b0, 4'b0000);
        wait_fd4(n);
        check_frame4(2, 32'h0000_2222);
        push_frame4(32'h0000_2222, 32'h0, 1'b0, 3'd0, 1'b0, 4'b0000);
        check_frame4(-1, 32'h0);

        // One-cycle reset in the middle of digit 2, then a full clean frame.
        repeat (11) @(negedge clk);
        chk("pre_rst_an", 32'(if4.an), 32'hB);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_an", 32'(if4.an), 32'hF);
        chk("mid_rst_seg", 32'(if4.seg), 32'h7F);
        chk("mid_rst_dp", 32'(if4.dp), 1);
        chk("mid_rst_fd", 32'(if4.frame_done), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_fd", 32'(if4.frame_done), 1);
        push_frame4(32'h0000_2222, 32'h0, 1'b0, 3'd0, 1'b0, 4'b0000);
        check_frame4(-1, 32'h0);

        // 8 digits, page 1 of a 32-bit source: every nibble lies beyond the register.
        for (int k = 0; k < 8; k++) begin
            e.an  = ~(8'h01 << k);
            e.seg = DEC[0];
            e.dp  = 1'b1;
            sb8.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if8.frame_done && n < 200);
        chk("fd8_wait", 32'(if8.frame_done), 1);
        for (int k = 0; k < 8; k++) begin
            e = sb8.pop_front();
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                chk($sformatf("d8_%0d_an", k), 32'(if8.an), 32'(e.an));
                chk($sformatf("d8_%0d_seg", k), 32'(if8.seg), 32'(e.seg));
                chk($sformatf("d8_%0d_dp", k), 32'(if8.dp), 32'(e.dp));
                chk($sformatf("d8_%0d_known", k), 32'($isunknown(if8.seg)), 0);
            end
        end
        chk("fd8_period", 32'(if8.frame_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
